// File: rtl/wb_commit_unit_pkg.sv
// rtl/wb_commit_unit_pkg.sv - shared ISA constants and trace record type for the WB commit unit
package wb_commit_unit_pkg;

    localparam int WORD_W = 32;
    localparam int REG_W  = 5;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] FN_JALR    = 6'h09;
    localparam logic [5:0] FN_MFHI    = 6'h10;
    localparam logic [5:0] FN_MTHI    = 6'h11;
    localparam logic [5:0] FN_MFLO    = 6'h12;
    localparam logic [5:0] FN_MTLO    = 6'h13;

    // One commit record as stored in the trace FIFO (101 bits).
    typedef struct packed {
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] instr;
        logic [REG_W-1:0]  rd;
        logic [WORD_W-1:0] data;
    } trace_rec_t;

    localparam int TRACE_W = $bits(trace_rec_t);

    // True when instr is an R-type (SPECIAL) instruction with the given funct.
    function automatic logic is_special_fn(input logic [WORD_W-1:0] instr, input logic [5:0] fn);
        return (instr[31:26] == OP_SPECIAL) && (instr[5:0] == fn);
    endfunction

endpackage

// File: rtl/wb_commit_unit_if.sv
// rtl/wb_commit_unit_if.sv - WB-stage inputs, register-file write port and trace port bundle
// Ports: WB fields (wbNextPC..wbWriteLoHi), traceReady in from the pipeline/sink side;
//        regWrite*, hi/lo, retiredCount, trace* out from the commit unit.
interface wb_commit_unit_if #(
    parameter int CNT_W = 32
);
    import wb_commit_unit_pkg::*;

    logic [WORD_W-1:0] wbNextPC;
    logic [WORD_W-1:0] wbInstruction;
    logic [WORD_W-1:0] wbALUOut;
    logic [WORD_W-1:0] wbALUOutHi;
    logic [WORD_W-1:0] wbMemOut;
    logic [REG_W-1:0]  wbWriteReg;
    logic              wbMemRead;
    logic              wbWriteLoHi;

    logic              regWriteEn;
    logic [REG_W-1:0]  regWriteAddr;
    logic [WORD_W-1:0] regWriteData;
    logic [WORD_W-1:0] hi;
    logic [WORD_W-1:0] lo;
    logic [CNT_W-1:0]  retiredCount;

    logic              traceValid;
    logic              traceReady;
    logic [WORD_W-1:0] tracePC;
    logic [WORD_W-1:0] traceInstr;
    logic [REG_W-1:0]  traceReg;
    logic [WORD_W-1:0] traceData;
    logic              traceOverflow;

    // Pipeline / sink side.
    modport master (
        output wbNextPC, wbInstruction, wbALUOut, wbALUOutHi, wbMemOut,
               wbWriteReg, wbMemRead, wbWriteLoHi, traceReady,
        input  regWriteEn, regWriteAddr, regWriteData, hi, lo, retiredCount,
               traceValid, tracePC, traceInstr, traceReg, traceData, traceOverflow
    );

    // Commit unit side.
    modport slave (
        input  wbNextPC, wbInstruction, wbALUOut, wbALUOutHi, wbMemOut,
               wbWriteReg, wbMemRead, wbWriteLoHi, traceReady,
        output regWriteEn, regWriteAddr, regWriteData, hi, lo, retiredCount,
               traceValid, tracePC, traceInstr, traceReg, traceData, traceOverflow
    );

endinterface

// File: rtl/commit_trace_fifo.sv
// rtl/commit_trace_fifo.sv - commit record FIFO with drop-on-full and sticky overflow flag
// Ports: i_clk, i_rst (async, active-high); i_push/i_data write side; i_pop read side
//        (ignored when empty); o_data head word, o_empty, o_overflow (sticky until reset).
module commit_trace_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 101
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty,
    output logic             o_overflow
);
    localparam int            AW     = $clog2(DEPTH);
    localparam logic [AW:0]   L_FULL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             r_overflow;

    logic w_full;
    logic w_do_pop;
    logic w_do_push;

    assign w_full   = (r_count == L_FULL);
    assign o_empty  = (r_count == '0);
    assign w_do_pop = i_pop && !o_empty;
    // A pop on the same edge frees the slot, so a full FIFO still accepts the push.
    assign w_do_push = i_push && (!w_full || w_do_pop);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - 1'b1;
            end
            if (i_push && !w_do_push) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Storage needs no reset: entries are only visible once counted.
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    assign o_data     = r_mem[r_rd_ptr];
    assign o_overflow = r_overflow;

endmodule

// File: rtl/wb_commit_unit.sv
// rtl/wb_commit_unit.sv - WB commit: GPR write port, architectural HI/LO, retire counter, trace FIFO
// Ports: i_clk, i_rst (async, active-high); bus (wb_commit_unit_if.slave) carrying the WB
//        fields in and the register-file write port, HI/LO, retiredCount and trace stream out.
module wb_commit_unit
    import wb_commit_unit_pkg::*;
#(
    parameter int TRACE_DEPTH = 8,
    parameter int CNT_W       = 32
) (
    input  logic                i_clk,
    input  logic                i_rst,
    wb_commit_unit_if.slave     bus
);
    logic              w_retire;
    logic              w_reg_we;
    logic              w_is_jal;
    logic              w_is_jalr;
    logic              w_is_mfhi;
    logic              w_is_mflo;
    logic              w_is_mthi;
    logic              w_is_mtlo;
    logic [WORD_W-1:0] w_wdata;
    logic [WORD_W-1:0] r_hi;
    logic [WORD_W-1:0] r_lo;
    logic [CNT_W-1:0]  r_retired_count;
    trace_rec_t        w_push_rec;
    trace_rec_t        w_head_rec;
    logic              w_empty;
    logic              w_overflow;

    // An all-zero instruction word is a pipeline bubble.
    assign w_retire  = (bus.wbInstruction != '0);
    assign w_reg_we  = w_retire && (bus.wbWriteReg != '0);
    assign w_is_jal  = (bus.wbInstruction[31:26] == OP_JAL);
    assign w_is_jalr = is_special_fn(bus.wbInstruction, FN_JALR);
    assign w_is_mfhi = is_special_fn(bus.wbInstruction, FN_MFHI);
    assign w_is_mflo = is_special_fn(bus.wbInstruction, FN_MFLO);
    assign w_is_mthi = is_special_fn(bus.wbInstruction, FN_MTHI);
    assign w_is_mtlo = is_special_fn(bus.wbInstruction, FN_MTLO);

    // MFHI/MFLO read the registered pair, i.e. what earlier instructions committed.
    always_comb begin
        w_wdata = bus.wbALUOut;
        if (bus.wbMemRead) begin
            w_wdata = bus.wbMemOut;
        end else if (w_is_jal || w_is_jalr) begin
            w_wdata = bus.wbNextPC;
        end else if (w_is_mfhi) begin
            w_wdata = r_hi;
        end else if (w_is_mflo) begin
            w_wdata = r_lo;
        end
    end

    assign bus.regWriteEn   = w_reg_we;
    assign bus.regWriteAddr = bus.wbWriteReg;
    assign bus.regWriteData = w_wdata;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_hi            <= '0;
            r_lo            <= '0;
            r_retired_count <= '0;
        end else if (w_retire) begin
            r_retired_count <= r_retired_count + 1'b1;
            if (bus.wbWriteLoHi) begin
                // MTHI/MTLO move a single GPR value into one half only.
                if (w_is_mthi) begin
                    r_hi <= bus.wbALUOut;
                end else if (w_is_mtlo) begin
                    r_lo <= bus.wbALUOut;
                end else begin
                    r_hi <= bus.wbALUOutHi;
                    r_lo <= bus.wbALUOut;
                end
            end
        end
    end

    assign bus.hi           = r_hi;
    assign bus.lo           = r_lo;
    assign bus.retiredCount = r_retired_count;

    always_comb begin
        w_push_rec.pc    = bus.wbNextPC - 32'd4;
        w_push_rec.instr = bus.wbInstruction;
        w_push_rec.rd    = w_reg_we ? bus.wbWriteReg : '0;
        w_push_rec.data  = w_reg_we ? w_wdata : '0;
    end

    commit_trace_fifo #(
        .DEPTH (TRACE_DEPTH),
        .WIDTH (TRACE_W)
    ) u_trace_fifo (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_push     (w_retire),
        .i_data     (w_push_rec),
        .i_pop      (bus.traceReady),
        .o_data     (w_head_rec),
        .o_empty    (w_empty),
        .o_overflow (w_overflow)
    );

    assign bus.traceValid    = !w_empty;
    assign bus.tracePC       = w_head_rec.pc;
    assign bus.traceInstr    = w_head_rec.instr;
    assign bus.traceReg      = w_head_rec.rd;
    assign bus.traceData     = w_head_rec.data;
    assign bus.traceOverflow = w_overflow;

endmodule
